lut_coeff_bank: RTL
===================

LUT_COEFF_BANK -- requirements
Module: lut_coeff_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32, coefficient word width in bits.
REQ-002 Parameter DEPTH, default 3072, entries per bank, 2 <= DEPTH <= 2^ADDR_WIDTH.
REQ-003 Parameter ADDR_WIDTH, default 12, read address width.
REQ-004 Parameter NUM_BANKS, default 4, coefficient banks read in parallel (c0..c(N-1)); 1 <= NUM_BANKS <= 16.
REQ-005 The block SHALL have one clock, clock; reset is asynchronous and active-high, port reset.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 load_start  input  1  begin or restart a full table load.
REQ-009 load_valid  input  1  load_data holds a valid word this cycle.
REQ-010 load_data  input  DATA_WIDTH  load word.
REQ-011 load_ready  output  1  high while in LOAD; words are accepted only when load_valid and load_ready.
REQ-012 load_done  output  1  one-cycle pulse on acceptance of the final load word.
REQ-013 table_ready  output  1  high in READY state.
REQ-014 rd_valid  input  1  read request.
REQ-015 rd_addr  input  ADDR_WIDTH  read entry index.
REQ-016 rd_q  output  NUM_BANKS*DATA_WIDTH  bank k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-017 rd_q_valid  output  1  rd_q holds a read result.
REQ-018 err_clear  input  1  clears rd_error.
REQ-019 rd_error  output  1  sticky flag for an illegal read.

Function
REQ-020 The FSM SHALL have exactly three states: EMPTY, LOAD and READY.
REQ-021 Transitions: EMPTY or READY with load_start moves to LOAD; LOAD with the final word accepted moves to READY; load_start while in LOAD stays in LOAD and zeroes both counters.
REQ-022 Load order SHALL be word counter 0..DEPTH-1 within a bank; on wrap to 0 the bank counter increments; total NUM_BANKS*DEPTH words.
REQ-023 An accepted word SHALL be written to bank[bank_cnt][word_cnt] on the same clock edge.
REQ-024 The final word is bank NUM_BANKS-1, entry DEPTH-1; load_done SHALL be high the cycle after its acceptance, for exactly one cycle, coincident with table_ready first rising.
REQ-025 load_start takes priority over a coincident load_valid; that word SHALL be discarded.
REQ-026 load_valid outside LOAD SHALL be ignored.
REQ-027 Reads SHALL be accepted only in READY with rd_addr < DEPTH.
REQ-028 Read latency SHALL be fixed at 2 cycles: a request at edge N produces rd_q_valid=1 with data after edge N+2 (address register, then output register). One request per cycle, fully pipelined, no backpressure.
REQ-029 An illegal read (not READY, or rd_addr >= DEPTH) SHALL still return rd_q_valid after 2 cycles with rd_q all zeros, and SHALL set rd_error.
REQ-030 rd_error SHALL stay set until err_clear or reset; a simultaneous err_clear and new illegal read leaves rd_error=1.
REQ-031 A read issued in READY SHALL complete with the pre-load data if load_start arrives while it is in flight.
REQ-032 Reading an entry in the cycle after its write is not possible, because READY follows the final write.
REQ-033 rd_q SHALL hold its last value when rd_q_valid=0.
REQ-034 RAM contents SHALL have no initialisation file; contents are undefined until the first load completes.

Reset
REQ-035 On reset assertion: state=EMPTY, counters=0, load_ready=0, load_done=0, table_ready=0, rd_q_valid=0, rd_q=0, rd_error=0, and the pipeline valid bits are flushed.
REQ-036 RAM contents SHALL NOT be reset.
REQ-037 Reset during LOAD SHALL return to EMPTY; a new load_start is needed.

Verification
REQ-038 With NUM_BANKS=2 and DEPTH=4: load_start, then 8 words 0x10..0x17 with load_valid=1 -> load_done pulse 1 cycle after word 0x17; read addr 2 -> rd_q = {0x16,0x12} 2 cycles later.
REQ-039 Back-to-back reads of addr 0,1,2,3 on consecutive cycles -> rd_q_valid high for 4 consecutive cycles starting 2 cycles after the first read, with data in order.
REQ-040 rd_valid with rd_addr=DEPTH in READY -> rd_q=0 and rd_q_valid=1 after 2 cycles, rd_error=1 until err_clear.
REQ-041 load_start after word 5 of 8 -> counters reset; the next 8 words reload from bank 0 entry 0; load_done fires only after the 8th new word.
REQ-042 Reset asserted mid-load at word 3 -> all outputs at reset values immediately; table_ready stays 0 through 10 idle cycles.
REQ-043 Read in READY, then load_start the next cycle -> the in-flight read returns the old data; a read in LOAD returns 0 and sets rd_error.

Source files
------------

// File: rtl/lut_coeff_bank.sv
// Parallel coefficient table: a stream of NUM_BANKS*DEPTH words fills the banks, then all banks are read in parallel.
// Reads return 2 clocks after the request, one per clock, with no read backpressure; load words are taken only while load_ready is high.
module lut_coeff_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3072,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_BANKS  = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            load_start,
    input  logic                            load_valid,
    input  logic [DATA_WIDTH-1:0]           load_data,
    output logic                            load_ready,
    output logic                            load_done,
    output logic                            table_ready,
    input  logic                            rd_valid,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] rd_q,
    output logic                            rd_q_valid,
    input  logic                            err_clear,
    output logic                            rd_error
);
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [IDX_W-1:0]      LAST_WORD = IDX_W'(DEPTH - 1);
    localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOAD,
        ST_READY
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                word_cnt_q, word_cnt_d;
    logic [BANK_W-1:0]               bank_cnt_q, bank_cnt_d;
    logic                            load_done_q;
    logic                            wr_en;
    logic                            last_acc;
    logic                            rd_ok;
    logic                            rd_vld1_q;
    logic                            rd_ok1_q;
    logic [IDX_W-1:0]                rd_idx1_q;
    logic                            rd_q_valid_q;
    logic [NUM_BANKS*DATA_WIDTH-1:0] rd_q_q;
    logic                            rd_error_q, rd_error_d;
    logic [DATA_WIDTH-1:0]           bank_rd [NUM_BANKS];

    // load_start wins over a coincident word, which is dropped
    assign wr_en    = (state_q == ST_LOAD) && load_valid && !load_start;
    assign last_acc = wr_en && (word_cnt_q == LAST_WORD) && (bank_cnt_q == LAST_BANK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load_start) state_d = ST_LOAD;
            ST_LOAD:  if (!load_start && last_acc) state_d = ST_READY;
            ST_READY: if (load_start) state_d = ST_LOAD;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        load_ready  = (state_q == ST_LOAD);
        table_ready = (state_q == ST_READY);
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        bank_cnt_d = bank_cnt_q;
        if (load_start) begin
            word_cnt_d = '0;
            bank_cnt_d = '0;
        end else if (wr_en) begin
            if (word_cnt_q == LAST_WORD) begin
                word_cnt_d = '0;
                bank_cnt_d = (bank_cnt_q == LAST_BANK) ? '0 : bank_cnt_q + BANK_W'(1);
            end else begin
                word_cnt_d = word_cnt_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            word_cnt_q  <= '0;
            bank_cnt_q  <= '0;
            load_done_q <= 1'b0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            bank_cnt_q  <= bank_cnt_d;
            load_done_q <= last_acc;
        end
    end

    // Legality is judged at request time, so a read already in flight keeps its data across a reload
    assign rd_ok      = (state_q == ST_READY) && ({1'b0, rd_addr} < DEPTH_LIM);
    assign rd_error_d = (rd_error_q && !err_clear) || (rd_valid && !rd_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld1_q  <= 1'b0;
            rd_ok1_q   <= 1'b0;
            rd_idx1_q  <= '0;
            rd_error_q <= 1'b0;
        end else begin
            rd_vld1_q  <= rd_valid;
            rd_ok1_q   <= rd_valid && rd_ok;
            rd_idx1_q  <= rd_addr[IDX_W-1:0];
            rd_error_q <= rd_error_d;
        end
    end

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clock) begin
            if (wr_en && (bank_cnt_q == BANK_W'(k))) begin
                mem[word_cnt_q] <= load_data;
            end
        end

        assign bank_rd[k] = mem[rd_idx1_q];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q_q       <= '0;
            rd_q_valid_q <= 1'b0;
        end else begin
            rd_q_valid_q <= rd_vld1_q;
            if (rd_vld1_q) begin
                for (int k = 0; k < NUM_BANKS; k++) begin
                    rd_q_q[k*DATA_WIDTH +: DATA_WIDTH] <= rd_ok1_q ? bank_rd[k] : '0;
                end
            end
        end
    end

    assign load_done  = load_done_q;
    assign rd_q       = rd_q_q;
    assign rd_q_valid = rd_q_valid_q;
    assign rd_error   = rd_error_q;

endmodule
